// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core, one round per clock, on-the-fly key expansion.
// Ports:
//   AES_clk            clock, rising edge
//   AES_rst_n          synchronous active-low reset
//   AES_en             start request; a rising edge while idle starts one block
//   AES_data_in        128-bit plaintext, bits [127:120] = byte 0
//   AES_key_in         128-bit cipher key, same byte order
//   AES_data_out       128-bit ciphertext, holds the last result
//   AES_data_out_valid one-cycle pulse marking a new AES_data_out
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);
    typedef enum logic {IDLE, BUSY} fsm_t;

    fsm_t         fsm, fsm_next;
    logic         en_q, start, last;
    logic [3:0]   round;
    logic [7:0]   rc;
    logic [127:0] st, rk, sb, sr, mc, nk, rnd_out;
    logic [31:0]  rot, ks, tw;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ t : p;
            t = xt(t);
        end
        return p;
    endfunction

    // Inverse as x^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sb[127-8*(4*c+r) -: 8] = sbox(st[127-8*(4*c+r) -: 8]);
            // row r rotates left by r columns
            assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc[127-32*r -: 32] = mix(sr[127-32*r -: 32]);
        assign ks[31-8*r -: 8] = sbox(rot[31-8*r -: 8]);
    end

    assign rot = {rk[23:0], rk[31:24]};
    assign tw = ks ^ {rc, 24'h0};
    assign nk[127:96] = rk[127:96] ^ tw;
    assign nk[95:64] = rk[95:64] ^ nk[127:96];
    assign nk[63:32] = rk[63:32] ^ nk[95:64];
    assign nk[31:0] = rk[31:0] ^ nk[63:32];

    assign last = round == 4'd10;
    assign rnd_out = (last ? sr : mc) ^ nk;
    assign start = AES_en && !en_q && fsm == IDLE;

    always_comb begin
        fsm_next = fsm;
        fsm_next = start ? BUSY : (fsm == BUSY && last) ? IDLE : fsm;
    end

    always_ff @(posedge AES_clk) begin
        fsm <= !AES_rst_n ? IDLE : fsm_next;
    end

    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            en_q <= 1'b0;
            round <= 4'd0;
            rc <= 8'h01;
            st <= '0;
            rk <= '0;
            AES_data_out <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            en_q <= AES_en;
            AES_data_out_valid <= 1'b0;
            if (start) begin
                st <= AES_data_in ^ AES_key_in;
                rk <= AES_key_in;
                rc <= 8'h01;
                round <= 4'd1;
            end else if (fsm == BUSY) begin
                st <= rnd_out;
                rk <= nk;
                rc <= xt(rc);
                round <= last ? 4'd0 : round + 4'd1;
                if (last) begin
                    AES_data_out <= rnd_out;
                    AES_data_out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_top.sv
// tb_aes_top: scoreboard bench for aes_top using FIPS-197 and all-zero vectors.
module tb_aes_top;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] key = '0;
    logic [127:0] dout;
    logic         valid;

    typedef struct {
        logic [127:0] d;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_top dut (
        .AES_clk(clk),
        .AES_rst_n(rst_n),
        .AES_en(en),
        .AES_data_in(din),
        .AES_key_in(key),
        .AES_data_out(dout),
        .AES_data_out_valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected block, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    check("ciphertext", dout, e.d);
                    check("latency", 128'(cyc), 128'(e.due));
                end
            end
        end
    end

    // Caller is just after a rising edge; the start edge is the next one.
    task automatic start_block(input logic [127:0] k, input logic [127:0] p,
                               input logic [127:0] c, input int hold, input bit push);
        exp_t e;
        key = k;
        din = p;
        en = 1'b1;
        if (push) begin
            e.d = c;
            e.due = cyc + 11;
            q.push_back(e);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", dout, '0);
        check("reset_valid", 128'(valid), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_block(K_C1, P_C1, C_C1, 1, 1'b1);
        drain();

        start_block(K_B, P_B, C_B, 51, 1'b1);
        drain();

        start_block('0, '0, C_Z, 1, 1'b1);
        drain();

        start_block(K_B, P_B, C_B, 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            din = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            en = i[0];
        end
        en = 1'b0;
        drain();

        start_block(K_C1, P_C1, C_C1, 1, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("after_abort_data_out", dout, '0);
        start_block(K_C1, P_C1, C_C1, 1, 1'b1);
        drain();

        start_block(K_C1, P_C1, C_C1, 1, 1'b1);
        for (int i = 0; i < 30 && valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        start_block(K_B, P_B, C_B, 1, 1'b1);
        drain();

        check("queue_empty", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_top.md
# aes_top

Iterative AES-128 encryption core: one 128-bit plaintext block and one 128-bit cipher key in, one 128-bit ciphertext block out. It computes one round per clock with on-the-fly key expansion. It is the top-level crypto datapath; the surrounding logic pulses an enable and waits for a valid strobe. Encryption only; no decryption and no key caching between blocks.

## Interface
- No parameters (fixed AES-128: 10 rounds, 128-bit key).
- AES_clk  in  1  single clock; all state updates on the rising edge.
- AES_rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of AES_clk.
- AES_en  in  1  start request, level input; a rising edge starts one encryption.
- AES_data_in  in  128  plaintext; bits [127:120] are FIPS-197 byte 0.
- AES_key_in  in  128  cipher key, same byte order.
- AES_data_out  out  128  ciphertext, same byte order; holds the last result.
- AES_data_out_valid  out  1  one-cycle pulse marking a new AES_data_out.

## Operation
- Byte mapping: byte i sits at bits [127-8i -: 8]. The state is column-major per FIPS-197: state[r][c] = byte 4c+r.
- Start condition: AES_en=1 in this cycle, AES_en registered low in the previous cycle, and the core is IDLE. Holding AES_en high does not retrigger.
- A start edge while the core is BUSY is ignored, and the in-flight block completes.
- On start, in the same edge:
  - state ← AES_data_in ^ AES_key_in (round 0 AddRoundKey);
  - round key register ← AES_key_in;
  - round counter ← 1;
  - go to BUSY.
- The inputs are sampled only at the start edge. Changes after that edge have no effect on the block in progress.
- BUSY, rounds 1..9, one per cycle: SubBytes, ShiftRows, MixColumns, AddRoundKey with the next expanded key.
- Key expansion step: rk' = expand(rk, Rcon[round]). Rcon = 01,02,04,08,10,20,40,80,1b,36.
- Round 10: SubBytes, ShiftRows, AddRoundKey; no MixColumns.
- After round 10:
  - AES_data_out ← result;
  - AES_data_out_valid ← 1 for exactly one cycle;
  - return to IDLE.
- S-box: standard AES forward S-box, either a ROM or a GF(2^8) inverse plus affine transform. It must be combinational; 16 datapath instances plus 4 for the key schedule.
- FSM states: IDLE, BUSY. There is no other state.

## Timing
- Reset (AES_rst_n=0 at a clock edge):
  - AES_data_out = 0, AES_data_out_valid = 0;
  - FSM = IDLE, round counter = 0;
  - the registered AES_en history = 0.
- Reset has priority over everything, including mid-encryption: the block in flight is discarded and no valid pulse is produced.
- The first rising edge of AES_en after reset release counts as a start, because the history register is 0.
- Latency: the start is sampled at edge N. Rounds 1..10 complete at edges N+1..N+10. AES_data_out and AES_data_out_valid update at edge N+10, so valid is high during cycle N+10 to N+11.
- Throughput: one block per 11 cycles at most. A new start is accepted at the edge after valid (IDLE).
- AES_data_out is stable between valid pulses; AES_data_out_valid is registered.

## Test plan
- Reset, then FIPS-197 Appendix C.1 vector (key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff), AES_en raised for 1 cycle -> AES_data_out = 69c4e0d86a7b0430d8cdb78070b4c55a with a single valid pulse exactly 10 edges after the start edge.
- Appendix B vector (key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734), AES_en held high for 51 cycles -> AES_data_out = 3925841d02dc09fbdc118597196a0b32 with exactly one valid pulse (no retrigger).
- All-zero key and plaintext -> AES_data_out = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Start with the Appendix B vector, then change AES_data_in/AES_key_in every cycle during BUSY, and toggle AES_en mid-block -> result is still 3925841d02dc09fbdc118597196a0b32, with only one valid pulse.
- Assert AES_rst_n=0 at round 5, release, wait 20 cycles -> no valid pulse and AES_data_out = 0. A following start with the C.1 vector -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Two back-to-back blocks (C.1, then B, each started the cycle after the previous valid) -> two valid pulses 11 cycles apart with the correct ciphertexts.
